// File: rtl/rs_multi_cdb_pkg.sv
// rtl/rs_multi_cdb_pkg.sv - shared constants for the multi-CDB reservation station
package rs_multi_cdb_pkg;

    localparam int DEF_RS_DEPTH  = 16;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ROB_TAG_W = 4;
    localparam int DEF_OP_W      = 6;
    localparam int DEF_NUM_CDB   = 2;

    // ROB tag value meaning "no dependency, value already present"
    localparam int ZERO_TAG_ROB  = 0;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_ADD = 6'd0,
        OP_SUB = 6'd1,
        OP_AND = 6'd2,
        OP_OR  = 6'd3,
        OP_XOR = 6'd4,
        OP_SLL = 6'd5,
        OP_SRL = 6'd6,
        OP_SLT = 6'd7
    } alu_op_e;

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - oldest-ready picker driven by an age matrix
module rs_age_select
    import rs_multi_cdb_pkg::*;
#(
    parameter int DEPTH = DEF_RS_DEPTH
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            sel_onehot,
    output logic [$clog2(DEPTH)-1:0]    sel_idx,
    output logic                        sel_valid
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] blocked;

    // An entry is blocked when any older entry (age[j][i]) is also ready
    always_comb begin
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && age[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
    end

    assign sel_onehot = ready & ~blocked;
    assign sel_valid  = |sel_onehot;

    // Encode the single surviving entry; lowest index wins if ever ambiguous
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel_onehot[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_multi_cdb.sv
// rtl/rs_multi_cdb.sv - reservation station with N CDB snoop ports and oldest-first issue
module rs_multi_cdb
    import rs_multi_cdb_pkg::*;
#(
    parameter int RS_DEPTH  = DEF_RS_DEPTH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ROB_TAG_W = DEF_ROB_TAG_W,
    parameter int OP_W      = DEF_OP_W,
    parameter int NUM_CDB   = DEF_NUM_CDB
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          in_dispatch_valid,
    output logic                          out_full,
    input  logic [ROB_TAG_W-1:0]          in_dispatch_rob_tag,
    input  logic [OP_W-1:0]               in_dispatch_op,
    input  logic [DATA_W-1:0]             in_dispatch_value1,
    input  logic [DATA_W-1:0]             in_dispatch_value2,
    input  logic [ROB_TAG_W-1:0]          in_dispatch_tag1,
    input  logic [ROB_TAG_W-1:0]          in_dispatch_tag2,
    input  logic [NUM_CDB-1:0]            in_cdb_valid,
    input  logic [NUM_CDB*ROB_TAG_W-1:0]  in_cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     in_cdb_value,
    input  logic                          in_flush,
    output logic                          out_alu_valid,
    input  logic                          in_alu_ready,
    output logic [OP_W-1:0]               out_alu_op,
    output logic [DATA_W-1:0]             out_alu_value1,
    output logic [DATA_W-1:0]             out_alu_value2,
    output logic [ROB_TAG_W-1:0]          out_alu_rob_tag
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam logic [ROB_TAG_W-1:0] ZT = ROB_TAG_W'(ZERO_TAG_ROB);

    logic [RS_DEPTH-1:0]               busy;
    logic [RS_DEPTH-1:0]               busy_nxt;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age;
    logic [RS_DEPTH-1:0]               ready;

    logic [OP_W-1:0]      e_op   [RS_DEPTH];
    logic [ROB_TAG_W-1:0] e_rob  [RS_DEPTH];
    logic [ROB_TAG_W-1:0] e_tag1 [RS_DEPTH];
    logic [ROB_TAG_W-1:0] e_tag2 [RS_DEPTH];
    logic [DATA_W-1:0]    e_val1 [RS_DEPTH];
    logic [DATA_W-1:0]    e_val2 [RS_DEPTH];

    logic [ROB_TAG_W-1:0] cdb_tag [NUM_CDB];
    logic [DATA_W-1:0]    cdb_val [NUM_CDB];

    logic [RS_DEPTH-1:0]  hit1;
    logic [RS_DEPTH-1:0]  hit2;
    logic [DATA_W-1:0]    cap1 [RS_DEPTH];
    logic [DATA_W-1:0]    cap2 [RS_DEPTH];

    logic [ROB_TAG_W-1:0] d_tag1;
    logic [ROB_TAG_W-1:0] d_tag2;
    logic [DATA_W-1:0]    d_val1;
    logic [DATA_W-1:0]    d_val2;

    logic [IDX_W-1:0]     free_idx;
    logic [RS_DEPTH-1:0]  sel_onehot;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_valid;
    logic                 do_dispatch;
    logic                 do_issue;

    for (genvar p = 0; p < NUM_CDB; p++) begin : g_cdb_unpack
        assign cdb_tag[p] = in_cdb_tag[p*ROB_TAG_W +: ROB_TAG_W];
        assign cdb_val[p] = in_cdb_value[p*DATA_W +: DATA_W];
    end

    assign out_full    = &busy;
    assign do_dispatch = in_dispatch_valid && !out_full && !in_flush;
    assign do_issue    = (!out_alu_valid || in_alu_ready) && sel_valid;

    // Lowest-index free entry receives the next dispatch
    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Issuable entries are judged from registered state only
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready[i] = busy[i] && (e_tag1[i] == ZT) && (e_tag2[i] == ZT);
        end
    end

    // Snoop every CDB port for waiting operands; iterating downwards lets port 0 win
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            hit1[i] = 1'b0;
            hit2[i] = 1'b0;
            cap1[i] = '0;
            cap2[i] = '0;
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (in_cdb_valid[p] && (cdb_tag[p] != ZT) && busy[i]) begin
                    if (cdb_tag[p] == e_tag1[i]) begin
                        hit1[i] = 1'b1;
                        cap1[i] = cdb_val[p];
                    end
                    if (cdb_tag[p] == e_tag2[i]) begin
                        hit2[i] = 1'b1;
                        cap2[i] = cdb_val[p];
                    end
                end
            end
        end
    end

    // Dispatch bypass: a broadcast in the dispatch cycle resolves the operand directly
    always_comb begin
        d_tag1 = in_dispatch_tag1;
        d_tag2 = in_dispatch_tag2;
        d_val1 = in_dispatch_value1;
        d_val2 = in_dispatch_value2;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (in_cdb_valid[p] && (cdb_tag[p] != ZT)) begin
                if (cdb_tag[p] == in_dispatch_tag1) begin
                    d_tag1 = ZT;
                    d_val1 = cdb_val[p];
                end
                if (cdb_tag[p] == in_dispatch_tag2) begin
                    d_tag2 = ZT;
                    d_val2 = cdb_val[p];
                end
            end
        end
    end

    rs_age_select #(
        .DEPTH(RS_DEPTH)
    ) u_age_select (
        .ready      (ready),
        .age        (age),
        .sel_onehot (sel_onehot),
        .sel_idx    (sel_idx),
        .sel_valid  (sel_valid)
    );

    // Issue frees the selected entry; dispatch claims the free one (never the same entry)
    always_comb begin
        busy_nxt = busy;
        if (do_issue) begin
            busy_nxt = busy_nxt & ~sel_onehot;
        end
        if (do_dispatch) begin
            busy_nxt[free_idx] = 1'b1;
        end
    end

    // Busy vector and age matrix; a new entry is younger than everything currently busy
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            age  <= '0;
        end else if (rdy) begin
            if (in_flush) begin
                busy <= '0;
            end else begin
                busy <= busy_nxt;
                if (do_dispatch) begin
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        age[j][free_idx] <= busy[j];
                    end
                    age[free_idx] <= '0;
                end
            end
        end
    end

    // Entry payload: dispatch writes the free entry, snoop fills waiting operands
    always_ff @(posedge clk) begin
        if (!rst && rdy && !in_flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (hit1[i]) begin
                    e_val1[i] <= cap1[i];
                    e_tag1[i] <= ZT;
                end
                if (hit2[i]) begin
                    e_val2[i] <= cap2[i];
                    e_tag2[i] <= ZT;
                end
            end
            if (do_dispatch) begin
                e_op[free_idx]   <= in_dispatch_op;
                e_rob[free_idx]  <= in_dispatch_rob_tag;
                e_tag1[free_idx] <= d_tag1;
                e_tag2[free_idx] <= d_tag2;
                e_val1[free_idx] <= d_val1;
                e_val2[free_idx] <= d_val2;
            end
        end
    end

    // Single issue register held stable until the ALU takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_alu_valid   <= 1'b0;
            out_alu_op      <= '0;
            out_alu_value1  <= '0;
            out_alu_value2  <= '0;
            out_alu_rob_tag <= '0;
        end else if (rdy) begin
            if (in_flush) begin
                out_alu_valid <= 1'b0;
            end else if (do_issue) begin
                out_alu_valid   <= 1'b1;
                out_alu_op      <= e_op[sel_idx];
                out_alu_value1  <= e_val1[sel_idx];
                out_alu_value2  <= e_val2[sel_idx];
                out_alu_rob_tag <= e_rob[sel_idx];
            end else if (in_alu_ready) begin
                out_alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb/tb_rs_multi_cdb.sv - scoreboard bench for rs_multi_cdb
module tb_rs_multi_cdb;
    import rs_multi_cdb_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        in_dispatch_valid;
    logic        out_full;
    logic [3:0]  in_dispatch_rob_tag;
    logic [5:0]  in_dispatch_op;
    logic [31:0] in_dispatch_value1;
    logic [31:0] in_dispatch_value2;
    logic [3:0]  in_dispatch_tag1;
    logic [3:0]  in_dispatch_tag2;
    logic [1:0]  in_cdb_valid;
    logic [7:0]  in_cdb_tag;
    logic [63:0] in_cdb_value;
    logic        in_flush;
    logic        out_alu_valid;
    logic        in_alu_ready;
    logic [5:0]  out_alu_op;
    logic [31:0] out_alu_value1;
    logic [31:0] out_alu_value2;
    logic [3:0]  out_alu_rob_tag;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  rob;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    rs_multi_cdb dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .in_dispatch_valid   (in_dispatch_valid),
        .out_full            (out_full),
        .in_dispatch_rob_tag (in_dispatch_rob_tag),
        .in_dispatch_op      (in_dispatch_op),
        .in_dispatch_value1  (in_dispatch_value1),
        .in_dispatch_value2  (in_dispatch_value2),
        .in_dispatch_tag1    (in_dispatch_tag1),
        .in_dispatch_tag2    (in_dispatch_tag2),
        .in_cdb_valid        (in_cdb_valid),
        .in_cdb_tag          (in_cdb_tag),
        .in_cdb_value        (in_cdb_value),
        .in_flush            (in_flush),
        .out_alu_valid       (out_alu_valid),
        .in_alu_ready        (in_alu_ready),
        .out_alu_op          (out_alu_op),
        .out_alu_value1      (out_alu_value1),
        .out_alu_value2      (out_alu_value2),
        .out_alu_rob_tag     (out_alu_rob_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted issue must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && rdy && !in_flush && out_alu_valid && in_alu_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected actual op=%0h v1=%0h v2=%0h rob=%0h required=no issue",
                         out_alu_op, out_alu_value1, out_alu_value2, out_alu_rob_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_alu_op !== e.op || out_alu_value1 !== e.v1 ||
                    out_alu_value2 !== e.v2 || out_alu_rob_tag !== e.rob) begin
                    failures++;
                    $display("FAIL issue_payload actual op=%0h v1=%0h v2=%0h rob=%0h required op=%0h v1=%0h v2=%0h rob=%0h",
                             out_alu_op, out_alu_value1, out_alu_value2, out_alu_rob_tag,
                             e.op, e.v1, e.v2, e.rob);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [3:0] rob);
        exp_t e;
        e.op = op; e.v1 = v1; e.v2 = v2; e.rob = rob;
        sb.push_back(e);
    endtask

    task automatic set_cdb(input int p, input logic [3:0] tag, input logic [31:0] val);
        in_cdb_valid[p]       = 1'b1;
        in_cdb_tag[p*4 +: 4]  = tag;
        in_cdb_value[p*32 +: 32] = val;
    endtask

    task automatic clear_cdb();
        in_cdb_valid = '0;
        in_cdb_tag   = '0;
        in_cdb_value = '0;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [3:0] rob,
                            input logic [31:0] v1, input logic [3:0] t1,
                            input logic [31:0] v2, input logic [3:0] t2);
        in_dispatch_valid   = 1'b1;
        in_dispatch_op      = op;
        in_dispatch_rob_tag = rob;
        in_dispatch_value1  = v1;
        in_dispatch_tag1    = t1;
        in_dispatch_value2  = v2;
        in_dispatch_tag2    = t2;
        tick();
        in_dispatch_valid   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; in_flush = 1'b0; in_alu_ready = 1'b0;
        in_dispatch_valid = 1'b0; in_dispatch_op = '0; in_dispatch_rob_tag = '0;
        in_dispatch_value1 = '0; in_dispatch_value2 = '0;
        in_dispatch_tag1 = '0; in_dispatch_tag2 = '0;
        clear_cdb();
        idle(2);
        check("reset_valid", 32'(out_alu_valid), 32'd0);
        check("reset_full", 32'(out_full), 32'd0);
        check("reset_op", 32'(out_alu_op), 32'd0);
        check("reset_value1", out_alu_value1, 32'd0);
        check("reset_rob", 32'(out_alu_rob_tag), 32'd0);
        rst = 1'b0;
        idle(1);

        // Simple ready op
        in_alu_ready = 1'b1;
        push_exp(OP_ADD, 32'd5, 32'd7, 4'd1);
        dispatch(OP_ADD, 4'd1, 32'd5, 4'd0, 32'd7, 4'd0);
        check("t1_issue_valid", 32'(out_alu_valid), 32'd0);
        tick();
        check("t1_issue_next", 32'(out_alu_valid), 32'd1);
        idle(3);
        check("t1_empty_after", 32'(out_alu_valid), 32'd0);

        // Wake-up through CDB port 1 two cycles after dispatch
        push_exp(OP_SUB, 32'h55, 32'd10, 4'd2);
        dispatch(OP_SUB, 4'd2, 32'hDEAD, 4'd3, 32'd10, 4'd0);
        tick();
        set_cdb(1, 4'd3, 32'h55);
        tick();
        clear_cdb();
        check("t2_not_early", 32'(out_alu_valid), 32'd0);
        tick();
        check("t2_latency", 32'(out_alu_valid), 32'd1);
        check("t2_value1", out_alu_value1, 32'h55);
        idle(3);

        // Dispatch bypass on operand 2 via port 0
        push_exp(OP_AND, 32'd1, 32'd9, 4'd3);
        set_cdb(0, 4'd4, 32'd9);
        dispatch(OP_AND, 4'd3, 32'd1, 4'd0, 32'hBEEF, 4'd4);
        clear_cdb();
        tick();
        check("t3_bypass_valid", 32'(out_alu_valid), 32'd1);
        check("t3_bypass_value2", out_alu_value2, 32'd9);
        idle(3);

        // Both ports carry the same tag: port 0 wins
        push_exp(OP_SLT, 32'hA, 32'd2, 4'd4);
        dispatch(OP_SLT, 4'd4, 32'hDEAD, 4'd5, 32'd2, 4'd0);
        set_cdb(0, 4'd5, 32'hA);
        set_cdb(1, 4'd5, 32'hB);
        tick();
        clear_cdb();
        idle(3);

        // A broadcast of tag 0 must not overwrite a present operand
        push_exp(OP_SLL, 32'd3, 32'd4, 4'd12);
        set_cdb(0, 4'd0, 32'd99);
        dispatch(OP_SLL, 4'd12, 32'd3, 4'd0, 32'd4, 4'd0);
        clear_cdb();
        idle(3);

        // Dependent A then ready B: B goes first
        push_exp(OP_XOR, 32'd4, 32'd6, 4'd6);
        push_exp(OP_OR, 32'h20, 32'd1, 4'd5);
        dispatch(OP_OR, 4'd5, 32'd0, 4'd2, 32'd1, 4'd0);
        dispatch(OP_XOR, 4'd6, 32'd4, 4'd0, 32'd6, 4'd0);
        tick();
        set_cdb(1, 4'd2, 32'h20);
        tick();
        clear_cdb();
        idle(4);

        // Older entry at a higher index must win over a younger one at index 0
        in_alu_ready = 1'b0;
        push_exp(OP_ADD, 32'h9, 32'h90, 4'd9);
        push_exp(OP_SUB, 32'h77, 32'h100, 4'd10);
        push_exp(OP_AND, 32'hF0, 32'h0F, 4'd11);
        dispatch(OP_ADD, 4'd9, 32'h9, 4'd0, 32'h90, 4'd0);
        dispatch(OP_SUB, 4'd10, 32'h0, 4'd7, 32'h100, 4'd0);
        set_cdb(0, 4'd7, 32'h77);
        dispatch(OP_AND, 4'd11, 32'hF0, 4'd0, 32'h0F, 4'd0);
        clear_cdb();
        check("t4_slot_held", 32'(out_alu_rob_tag), 32'd9);
        in_alu_ready = 1'b1;
        idle(5);

        // Fill: slot plus 16 entries, then an ignored dispatch
        in_alu_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            push_exp(6'(k % 8), 32'(k + 100), 32'(k * 3), 4'((k % 15) + 1));
            dispatch(6'(k % 8), 4'((k % 15) + 1), 32'(k + 100), 4'd0, 32'(k * 3), 4'd0);
            if (k == 15) check("t5_not_full_15", 32'(out_full), 32'd0);
        end
        check("t5_full", 32'(out_full), 32'd1);
        dispatch(OP_XOR, 4'd15, 32'hBAD, 4'd0, 32'hBAD, 4'd0);
        check("t5_full_after_drop", 32'(out_full), 32'd1);
        check("t5_slot_stable", out_alu_value1, 32'd100);
        in_alu_ready = 1'b1;
        tick();
        check("t5_full_drops", 32'(out_full), 32'd0);
        idle(20);
        check("t5_drained", 32'(out_alu_valid), 32'd0);

        // Flush with a loaded slot and waiting entries
        in_alu_ready = 1'b0;
        dispatch(OP_OR, 4'd13, 32'd1, 4'd0, 32'd2, 4'd0);
        for (int k = 1; k < 8; k++) begin
            dispatch(OP_ADD, 4'(k), 32'd0, 4'd9, 32'(k), 4'd0);
        end
        check("t6_pre_valid", 32'(out_alu_valid), 32'd1);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        check("t6_flush_valid", 32'(out_alu_valid), 32'd0);
        check("t6_flush_full", 32'(out_full), 32'd0);
        in_alu_ready = 1'b1;
        set_cdb(0, 4'd9, 32'h99);
        tick();
        clear_cdb();
        idle(5);
        check("t6_no_issue", 32'(out_alu_valid), 32'd0);

        // rdy=0 ignores dispatch entirely
        rdy = 1'b0;
        dispatch(OP_ADD, 4'd14, 32'd1, 4'd0, 32'd1, 4'd0);
        idle(2);
        check("t7_frozen_valid", 32'(out_alu_valid), 32'd0);
        check("t7_frozen_full", 32'(out_full), 32'd0);
        rdy = 1'b1;
        idle(3);
        check("t7_no_late_issue", 32'(out_alu_valid), 32'd0);

        for (int n = 0; n < 50 && sb.size() != 0; n++) tick();
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
